// File: rtl/mdu_seq_ctrl_if.sv
// rtl/mdu_seq_ctrl_if.sv - EX-stage to multiply/divide sequencer bus
interface mdu_seq_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic                  start;
  logic [5:0]            funct;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  stall_req;
  logic                  busy;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output flush, start, funct, operand_a, operand_b,
    input  stall_req, busy, hi, lo
  );

  modport slave (
    input  flush, start, funct, operand_a, operand_b,
    output stall_req, busy, hi, lo
  );
endinterface

// File: rtl/mdu_seq_ctrl.sv
// rtl/mdu_seq_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
module mdu_seq_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mdu_seq_ctrl_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_SIGN,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]   cnt;
  logic [2*DW-1:0] acc;
  logic [DW-1:0]   mcand;
  logic            is_div;
  logic            neg_q;
  logic            neg_r;
  logic [DW-1:0]   hi_r;
  logic [DW-1:0]   lo_r;
  logic            busy_r;

  logic            is_md;
  logic            is_mthi;
  logic            is_mtlo;
  logic            op_signed;
  logic            last;
  logic [DW-1:0]   abs_a;
  logic [DW-1:0]   abs_b;
  logic [DW:0]     mul_sum;
  logic [DW:0]     div_shift;
  logic [DW:0]     div_trial;
  logic [2*DW-1:0] prod_fix;
  logic [DW-1:0]   quot_fix;
  logic [DW-1:0]   rem_fix;

  assign is_md     = (bus.funct[5:2] == 4'b0110);
  assign is_mthi   = (bus.funct == 6'h11);
  assign is_mtlo   = (bus.funct == 6'h13);
  assign op_signed = ~bus.funct[0];
  assign last      = (cnt == CW'(DATA_WIDTH - 1));

  assign abs_a = (op_signed && bus.operand_a[DW-1]) ? (~bus.operand_a + 1'b1) : bus.operand_a;
  assign abs_b = (op_signed && bus.operand_b[DW-1]) ? (~bus.operand_b + 1'b1) : bus.operand_b;

  // Multiply: add multiplicand into the upper half when the lsb is set, then shift right.
  assign mul_sum = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, mcand} : {(DW+1){1'b0}});

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign div_shift = acc[2*DW-1:DW-1];
  assign div_trial = div_shift - {1'b0, mcand};

  assign prod_fix = neg_q ? (~acc + 1'b1) : acc;
  assign quot_fix = neg_q ? (~acc[DW-1:0] + 1'b1) : acc[DW-1:0];
  assign rem_fix  = neg_r ? (~acc[2*DW-1:DW] + 1'b1) : acc[2*DW-1:DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy_r <= 1'b0;
    end else begin
      state  <= state_next;
      busy_r <= (state_next != S_IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (bus.start && is_md) state_next = bus.funct[1] ? S_DIV : S_MUL;
      S_MUL:  if (last) state_next = S_SIGN;
      S_DIV:  if (last) state_next = S_SIGN;
      S_SIGN: state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (bus.flush) state_next = S_IDLE;
  end

  assign bus.stall_req = ~bus.flush &
                         (((state == S_IDLE) & bus.start & is_md) |
                          (state == S_MUL) | (state == S_DIV) | (state == S_SIGN));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else if (!bus.flush) begin
      case (state)
        S_IDLE: begin
          if (bus.start && is_md) begin
            cnt    <= '0;
            is_div <= bus.funct[1];
            if (bus.funct[1] && bus.operand_b == '0) begin
              // Divide by zero keeps the raw dividend so the remainder returns it untouched.
              acc   <= {{DW{1'b0}}, bus.operand_a};
              mcand <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (bus.funct[1]) begin
              acc   <= {{DW{1'b0}}, abs_a};
              mcand <= abs_b;
              neg_q <= op_signed & (bus.operand_a[DW-1] ^ bus.operand_b[DW-1]);
              neg_r <= op_signed & bus.operand_a[DW-1];
            end else begin
              acc   <= {{DW{1'b0}}, abs_b};
              mcand <= abs_a;
              neg_q <= op_signed & (bus.operand_a[DW-1] ^ bus.operand_b[DW-1]);
              neg_r <= 1'b0;
            end
          end else if (bus.start && is_mthi) begin
            hi_r <= bus.operand_a;
          end else if (bus.start && is_mtlo) begin
            lo_r <= bus.operand_a;
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[DW-1:1]};
          cnt <= cnt + 1'b1;
        end
        S_DIV: begin
          if (div_trial[DW])
            acc <= {div_shift[DW-1:0], acc[DW-2:0], 1'b0};
          else
            acc <= {div_trial[DW-1:0], acc[DW-2:0], 1'b1};
          cnt <= cnt + 1'b1;
        end
        S_SIGN: begin
          if (is_div) begin
            hi_r <= rem_fix;
            lo_r <= quot_fix;
          end else begin
            hi_r <= prod_fix[2*DW-1:DW];
            lo_r <= prod_fix[DW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// tb/tb_mdu_seq_ctrl.sv - directed self-checking bench for mdu_seq_ctrl
module tb_mdu_seq_ctrl;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mdu_seq_ctrl_if #(.DATA_WIDTH(32)) bus ();

  mdu_seq_ctrl #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one MD op, counts stall cycles, checks the DONE-cycle result and that
  // a start held through DONE is not taken.
  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    bus.start = 1'b1;
    bus.funct = f;
    bus.operand_a = a;
    bus.operand_b = b;
    n = 0;
    while (n < 40) begin
      #1;
      if (!bus.stall_req) break;
      n++;
      step();
      bus.start = 1'b0;
    end
    chk({tag, "_stall_cycles"}, 64'(n), 64'd34);
    chk({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    bus.start = 1'b1;
    bus.funct = 6'h19;
    step();
    bus.start = 1'b0;
    #1;
    chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    chk({tag, "_stall_after"}, 64'(bus.stall_req), 64'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    bus.funct = 6'h00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_stall", 64'(bus.stall_req), 64'd0);

    run_md("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_md("mult_neg", 6'h18, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_md("div_neg", 6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_negdiv", 6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_md("divu_zero", 6'h1B, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF);
    run_md("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    bus.start = 1'b1;
    bus.funct = 6'h11;
    bus.operand_a = 32'h12345678;
    #1;
    chk("mthi_stall", 64'(bus.stall_req), 64'd0);
    step();
    chk("mthi_hi", 64'(bus.hi), 64'h12345678);
    bus.funct = 6'h13;
    bus.operand_a = 32'hCAFEBABE;
    #1;
    chk("mtlo_stall", 64'(bus.stall_req), 64'd0);
    step();
    bus.start = 1'b0;
    chk("mtlo_lo", 64'(bus.lo), 64'hCAFEBABE);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);

    bus.start = 1'b1;
    bus.funct = 6'h1B;
    bus.operand_a = 32'd50;
    bus.operand_b = 32'd7;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", 64'(bus.stall_req), 64'd0);
    step();
    bus.flush = 1'b0;
    #1;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_hi", 64'(bus.hi), 64'h12345678);
    chk("flush_lo", 64'(bus.lo), 64'hCAFEBABE);

    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.funct = 6'h11;
    bus.operand_a = 32'hDEADBEEF;
    #1;
    chk("flush_start_stall", 64'(bus.stall_req), 64'd0);
    step();
    bus.flush = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("flush_mthi_hi", 64'(bus.hi), 64'h12345678);

    run_md("multu_6x7", 6'h19, 32'd6, 32'd7, 32'd0, 32'd42);

    bus.start = 1'b1;
    bus.funct = 6'h18;
    bus.operand_a = 32'd9;
    bus.operand_b = 32'd9;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 20; i++) step();
    chk("mid_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_stall", 64'(bus.stall_req), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in the EX stage, next to the ALU.
- Executes SPECIAL-class MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) and owns the HI/LO architectural registers.
- Services MTHI/MTLO writes and supplies HI/LO for MFHI/MFLO.
- Raises a stall request that holds the pipeline until the result is committed.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  pipeline flush; aborts any operation in progress.
- start  input  1  EX holds a valid SPECIAL-op instruction this cycle.
- funct  input  6  funct field of the EX instruction.
- operand_a  input  DATA_WIDTH  rs value; dividend/multiplicand; MTHI/MTLO source.
- operand_b  input  DATA_WIDTH  rt value; divisor/multiplier.
- stall_req  output  1  request to freeze IF/ID/EX; combinational.
- busy  output  1  high when state is not IDLE; registered.
- hi  output  DATA_WIDTH  current HI register.
- lo  output  DATA_WIDTH  current LO register.

Behaviour:
- Decoded funct codes: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13. All others are ignored (MFHI 0x10 and MFLO 0x12 read the hi/lo ports; no action here).
- Reset: state=IDLE, hi=0, lo=0, counter=0, internal regs=0, busy=0, stall_req=0.
- States and transitions:
  - IDLE: on start & MD funct (0x18–0x1B), latch operands. Signed ops latch absolute values plus result-sign flags (quotient sign = sign_a^sign_b; remainder sign = sign_a). Go to MUL or DIV. On start & MTHI: hi<=operand_a. On start & MTLO: lo<=operand_a. Both stay in IDLE, no stall.
  - MUL: shift-add, one multiplier bit per cycle, 2*DATA_WIDTH-bit accumulator. Counter 0..DATA_WIDTH-1; on the last count go to SIGN.
  - DIV: restoring division, one quotient bit per cycle. Same counter rule; on the last count go to SIGN.
  - SIGN: apply two's-complement negation per the latched flags. Product is negated as 64 bits. Commit hi/lo on the exit edge; go to DONE.
  - DONE: one cycle with stall_req=0 so the held instruction advances. start is ignored. Go to IDLE.
- stall_req = (state==IDLE & start & MD funct & !flush) | state==MUL | state==DIV | state==SIGN.
- Latency: accept cycle T0. Iterations T1..T32. SIGN at T33. DONE at T34 with the new hi/lo visible. stall_req is high T0..T33 (34 cycles).
- MULT/MULTU: hi=product[63:32], lo=product[31:0].
- DIV/DIVU: lo=quotient, hi=remainder. Remainder takes the sign of the dividend.
- Divide by zero: no trap. Iterations still run. Result is lo=0xFFFFFFFF and hi=dividend (unsigned path, natural restoring result); no sign fixup applied.
- Signed 0x80000000 / -1: lo=0x80000000, hi=0.
- Flush: in any state, next state is IDLE. hi/lo are unchanged, busy=0 next cycle, and stall_req drops combinationally in the flush cycle.
- flush & start in IDLE: the operation is not accepted, and MTHI/MTLO is not performed.
- rst has priority over flush and start. Reset mid-operation returns to IDLE and clears hi/lo.
- Counter wraps only via explicit reset to 0 on accept; it never free-runs.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF → stall_req high 34 cycles; at DONE hi=0xFFFFFFFE, lo=0x00000001; busy low the cycle after DONE.
- MULT -3*5 (0xFFFFFFFD, 5) → hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 → lo=0xFFFFFFFF, hi=0x00000064, same 34-cycle latency. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678 then MTLO 0xCAFEBABE back-to-back in IDLE → no stall; hi/lo updated the next cycle each.
- DIVU 50/7 started, flush asserted at T10 → stall_req low that cycle, IDLE next cycle, hi/lo retain prior values; a new MULTU 6*7 then yields lo=42, hi=0.
- rst asserted at T20 of a MULT → hi=lo=0, busy=0 next cycle; start held during the DONE cycle does not re-trigger an operation.
